// File: rtl/jump_ctrl.sv
// jump_ctrl: multi-cycle sequencer for the MIX jump instructions.
// Opcode 39 jumps test the comparison indicator / overflow toggle, opcodes
// 40..47 test a register fetched over the register-file read port. Each
// instruction ends in a single commit cycle that drives PC load, J write and
// overflow clear together with the done pulse.
module jump_ctrl #(
  parameter int PC_W      = 12,
  parameter int MEM_WORDS = 4000,
  parameter int RD_TMO    = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [5:0]      opcode,
  input  logic [5:0]      field,
  input  logic [PC_W-1:0] addr,
  input  logic [PC_W-1:0] pc,
  input  logic            cmp_l,
  input  logic            cmp_e,
  input  logic            cmp_g,
  input  logic            ovf,
  output logic            rd_req,
  output logic [2:0]      rd_idx,
  input  logic            rd_ack,
  input  logic [30:0]     rd_data,
  output logic            busy,
  output logic            done,
  output logic            taken,
  output logic            illegal,
  output logic            pc_load,
  output logic [PC_W-1:0] pc_next,
  output logic            j_we,
  output logic [PC_W-1:0] j_data,
  output logic            ovf_clr
);

  localparam int              CNT_W   = $clog2(RD_TMO + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TMO - 1);
  localparam logic [PC_W-1:0]  LAST_PC  = PC_W'(MEM_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RDREG,
    S_EVAL,
    S_DONE
  } state_t;

  state_t state;

  // Operands captured when a request is accepted.
  logic [5:0]      op_r;
  logic [5:0]      fld_r;
  logic [PC_W-1:0] addr_r;
  logic [PC_W-1:0] pc_r;
  logic            l_r;
  logic            e_r;
  logic            g_r;
  logic            ovf_r;
  logic [30:0]     data_r;

  // Read-phase bookkeeping.
  logic [CNT_W-1:0] cnt_r;
  logic             tmo_r;

  // Combinational evaluation of the latched instruction.
  logic            is_op39;
  logic            is_reg;
  logic            fld_ok;
  logic            bad;
  logic            mag_zero;
  logic            sgn;
  logic            cond;
  logic            eval_taken;
  logic            eval_jwe;
  logic            eval_ovf_clr;
  logic [PC_W-1:0] pc_inc;

  // A request goes to the register read phase only when it is a well-formed
  // register jump; anything else heads straight to evaluation.
  logic want_read;
  assign want_read = (opcode >= 6'd40) && (opcode <= 6'd47) && (field <= 6'd7);

  // Capture instruction operands on accept and register data on read ack.
  // NOTE: operand holding registers carry no reset; every path writes them before they are consumed.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      op_r   <= opcode;
      fld_r  <= field;
      addr_r <= addr;
      pc_r   <= pc;
      l_r    <= cmp_l;
      e_r    <= cmp_e;
      g_r    <= cmp_g;
      ovf_r  <= ovf;
    end
    if (state == S_RDREG && rd_ack) begin
      data_r <= rd_data;
    end
  end

  // Decode legality and the jump condition from the latched operands.
  // NOTE: every always_comb output is given a default first so no path can infer a latch.
  always_comb begin
    is_op39  = (op_r == 6'd39);
    is_reg   = (op_r >= 6'd40) && (op_r <= 6'd47);
    fld_ok   = is_op39 ? (fld_r <= 6'd9) : (fld_r <= 6'd7);
    bad      = ~(is_op39 | is_reg) | ~fld_ok | tmo_r;
    mag_zero = (data_r[29:0] == 30'd0);
    sgn      = data_r[30];
    cond     = 1'b0;
    pc_inc   = (pc_r == LAST_PC) ? '0 : pc_r + PC_W'(1);

    if (is_op39) begin
      case (fld_r[3:0])
        4'd0:    cond = 1'b1;            // JMP
        4'd1:    cond = 1'b1;            // JSJ
        4'd2:    cond = ovf_r;           // JOV
        4'd3:    cond = ~ovf_r;          // JNOV
        4'd4:    cond = l_r;             // JL
        4'd5:    cond = e_r;             // JE
        4'd6:    cond = g_r;             // JG
        4'd7:    cond = g_r | e_r;       // JGE
        4'd8:    cond = ~e_r;            // JNE
        4'd9:    cond = l_r | e_r;       // JLE
        default: cond = 1'b0;
      endcase
    end else begin
      // Minus zero has a zero magnitude, so it counts as zero here.
      case (fld_r[2:0])
        3'd0:    cond = ~mag_zero & sgn;     // N
        3'd1:    cond = mag_zero;            // Z
        3'd2:    cond = ~mag_zero & ~sgn;    // P
        3'd3:    cond = mag_zero | ~sgn;     // NN
        3'd4:    cond = ~mag_zero;           // NZ
        3'd5:    cond = mag_zero | sgn;      // NP
        3'd6:    cond = ~data_r[0];          // E
        3'd7:    cond = data_r[0];           // O
        default: cond = 1'b0;
      endcase
    end

    eval_taken   = cond & ~bad;
    // JSJ jumps without recording the return address.
    eval_jwe     = eval_taken & ~(is_op39 & (fld_r == 6'd1));
    // JOV and JNOV both consume a set overflow toggle, taken or not.
    eval_ovf_clr = ~bad & is_op39 & ((fld_r == 6'd2) | (fld_r == 6'd3)) & ovf_r;
  end

  // Sequencer state, read handshake, timeout counter and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt_r   <= '0;
      tmo_r   <= 1'b0;
      rd_req  <= 1'b0;
      rd_idx  <= 3'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      taken   <= 1'b0;
      illegal <= 1'b0;
      pc_load <= 1'b0;
      pc_next <= '0;
      j_we    <= 1'b0;
      j_data  <= '0;
      ovf_clr <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            cnt_r <= '0;
            tmo_r <= 1'b0;
            if (want_read) begin
              rd_req <= 1'b1;
              rd_idx <= opcode[2:0];  // 40..47 map onto 0..7
              state  <= S_RDREG;
            end else begin
              state  <= S_EVAL;
            end
          end
        end

        S_RDREG: begin
          if (rd_ack) begin
            rd_req <= 1'b0;
            state  <= S_EVAL;
          end else if (cnt_r == CNT_LAST) begin
            // RD_TMO request cycles have now gone unanswered.
            rd_req <= 1'b0;
            tmo_r  <= 1'b1;
            state  <= S_EVAL;
          end else begin
            cnt_r  <= cnt_r + CNT_W'(1);
          end
        end

        S_EVAL: begin
          taken   <= eval_taken;
          illegal <= bad;
          pc_next <= eval_taken ? addr_r : pc_inc;
          j_data  <= pc_inc;
          done    <= 1'b1;
          pc_load <= 1'b1;
          j_we    <= eval_jwe;
          ovf_clr <= eval_ovf_clr;
          state   <= S_DONE;
        end

        S_DONE: begin
          // Commit pulses last exactly one cycle; a start seen here is dropped.
          done    <= 1'b0;
          pc_load <= 1'b0;
          j_we    <= 1'b0;
          ovf_clr <= 1'b0;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jump_ctrl.sv
// Bench for jump_ctrl: table of jump vectors with hand-derived expectations,
// a scoreboard queue pushed at start and popped at done, and hand-written
// sequences for reset, start-while-busy and start-during-done.
module tb_jump_ctrl;

  localparam int PC_W      = 12;
  localparam int MEM_WORDS = 4000;
  localparam int RD_TMO    = 15;
  localparam int NO_ACK    = -1;
  localparam int BUDGET    = 40;

  logic            clk;
  logic            rst;
  logic            start;
  logic [5:0]      opcode;
  logic [5:0]      field;
  logic [PC_W-1:0] addr;
  logic [PC_W-1:0] pc;
  logic            cmp_l;
  logic            cmp_e;
  logic            cmp_g;
  logic            ovf;
  logic            rd_req;
  logic [2:0]      rd_idx;
  logic            rd_ack;
  logic [30:0]     rd_data;
  logic            busy;
  logic            done;
  logic            taken;
  logic            illegal;
  logic            pc_load;
  logic [PC_W-1:0] pc_next;
  logic            j_we;
  logic [PC_W-1:0] j_data;
  logic            ovf_clr;

  jump_ctrl #(
    .PC_W      (PC_W),
    .MEM_WORDS (MEM_WORDS),
    .RD_TMO    (RD_TMO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .opcode  (opcode),
    .field   (field),
    .addr    (addr),
    .pc      (pc),
    .cmp_l   (cmp_l),
    .cmp_e   (cmp_e),
    .cmp_g   (cmp_g),
    .ovf     (ovf),
    .rd_req  (rd_req),
    .rd_idx  (rd_idx),
    .rd_ack  (rd_ack),
    .rd_data (rd_data),
    .busy    (busy),
    .done    (done),
    .taken   (taken),
    .illegal (illegal),
    .pc_load (pc_load),
    .pc_next (pc_next),
    .j_we    (j_we),
    .j_data  (j_data),
    .ovf_clr (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]      op;
    logic [5:0]      fld;
    logic [PC_W-1:0] addr;
    logic [PC_W-1:0] pc;
    logic            l;
    logic            e;
    logic            g;
    logic            ovf;
    int              ack_dly;
    logic [30:0]     data;
  } stim_t;

  typedef struct {
    logic            taken;
    logic            illegal;
    logic [PC_W-1:0] pc_next;
    logic            j_we;
    logic [PC_W-1:0] j_data;
    logic            ovf_clr;
    logic [2:0]      rd_idx;
    logic            reads;
    int              lat;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  x;
  } vec_t;

  vec_t vecs[$];
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input int op, input int fld, input int a, input int p,
                     input bit l, input bit e, input bit g, input bit ov,
                     input int dly, input logic [30:0] data,
                     input bit tk, input bit ill, input int pcn, input bit jwe,
                     input int jd, input bit oc, input int idx, input bit reads,
                     input int lat);
    vec_t v;
    v.s.op = 6'(op);  v.s.fld = 6'(fld);
    v.s.addr = PC_W'(a);  v.s.pc = PC_W'(p);
    v.s.l = l;  v.s.e = e;  v.s.g = g;  v.s.ovf = ov;
    v.s.ack_dly = dly;  v.s.data = data;
    v.x.taken = tk;  v.x.illegal = ill;  v.x.pc_next = PC_W'(pcn);
    v.x.j_we = jwe;  v.x.j_data = PC_W'(jd);  v.x.ovf_clr = oc;
    v.x.rd_idx = 3'(idx);  v.x.reads = reads;  v.x.lat = lat;
    vecs.push_back(v);
  endtask

  // Drive one instruction, service the read port, and compare at done.
  task automatic run_vec(input vec_t v);
    int   cyc;
    int   nreq;
    bit   seen_done;
    bit   saw_req;
    exp_t x;
    @(negedge clk);
    opcode = v.s.op;  field = v.s.fld;  addr = v.s.addr;  pc = v.s.pc;
    cmp_l = v.s.l;  cmp_e = v.s.e;  cmp_g = v.s.g;  ovf = v.s.ovf;
    start = 1'b1;
    sb.push_back(v.x);
    @(negedge clk);
    start = 1'b0;
    // Inputs wander after acceptance; the result must not follow them.
    opcode = 6'($urandom);  field = 6'($urandom);
    addr = PC_W'($urandom);  pc = PC_W'($urandom);
    cmp_l = ~v.s.l;  cmp_e = ~v.s.e;  cmp_g = ~v.s.g;  ovf = ~v.s.ovf;
    cyc = 1;  nreq = 0;  seen_done = 0;  saw_req = 0;
    while (!seen_done && cyc <= BUDGET) begin
      if (cyc == 1) check("busy_after_start", busy, 1);
      if (done) begin
        x = sb.pop_front();
        check("latency", cyc, x.lat);
        check("taken", taken, x.taken);
        check("illegal", illegal, x.illegal);
        check("pc_next", pc_next, x.pc_next);
        check("j_we", j_we, x.j_we);
        check("j_data", j_data, x.j_data);
        check("ovf_clr", ovf_clr, x.ovf_clr);
        check("pc_load", pc_load, 1);
        check("read_issued", saw_req, x.reads);
        seen_done = 1;
      end else begin
        if (rd_req) begin
          if (!saw_req) check("rd_idx", rd_idx, x_idx(v));
          saw_req = 1;
          rd_ack  = (v.s.ack_dly != NO_ACK) && (nreq == v.s.ack_dly);
          rd_data = rd_ack ? v.s.data : 31'($urandom);
          nreq++;
        end else begin
          rd_ack = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    rd_ack = 1'b0;
    if (!seen_done) begin
      check("done_within_budget", 0, 1);
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("idle_after_done", busy, 0);
    end
  endtask

  function automatic logic [2:0] x_idx(input vec_t v);
    return v.x.rd_idx;
  endfunction

  initial begin
    int pulses;
    rst = 1'b1;  start = 1'b0;  opcode = '0;  field = '0;  addr = '0;  pc = '0;
    cmp_l = 1'b0;  cmp_e = 1'b0;  cmp_g = 1'b0;  ovf = 1'b0;
    rd_ack = 1'b0;  rd_data = '0;

    //   op  F   M     pc    l e g ov dly     data            tk il pcn  jwe jd  oc idx rd lat
    add(39,  0, 500,  100, 0,0,0,0, NO_ACK, 31'h0,          1, 0, 500, 1, 101, 0, 0, 0, 2);
    add(39,  1,   7, 3999, 0,0,0,0, NO_ACK, 31'h0,          1, 0,   7, 0,   0, 0, 0, 0, 2);
    add(39,  4,   7, 3999, 0,1,0,0, NO_ACK, 31'h0,          0, 0,   0, 0,   0, 0, 0, 0, 2);
    add(39,  2,  20,   10, 0,0,0,1, NO_ACK, 31'h0,          1, 0,  20, 1,  11, 1, 0, 0, 2);
    add(39,  3,  20,   10, 0,0,0,1, NO_ACK, 31'h0,          0, 0,  11, 0,  11, 1, 0, 0, 2);
    add(39,  3,  20,   10, 0,0,0,0, NO_ACK, 31'h0,          1, 0,  20, 1,  11, 0, 0, 0, 2);
    add(39,  6,  60,   40, 0,0,1,0, NO_ACK, 31'h0,          1, 0,  60, 1,  41, 0, 0, 0, 2);
    add(39,  9,  60,   40, 0,0,1,0, NO_ACK, 31'h0,          0, 0,  41, 0,  41, 0, 0, 0, 2);
    add(39,  8,  60,   40, 1,0,0,0, NO_ACK, 31'h0,          1, 0,  60, 1,  41, 0, 0, 0, 2);
    add(39,  0,  31,   30, 0,0,0,0, NO_ACK, 31'h0,          1, 0,  31, 1,  31, 0, 0, 0, 2);
    add(47,  0, 300,  200, 0,0,0,0, 3,      31'h40000000,   0, 0, 201, 0, 201, 0, 7, 1, 6);
    add(47,  1, 300,  200, 0,0,0,0, 3,      31'h40000000,   1, 0, 300, 1, 201, 0, 7, 1, 6);
    add(41,  7, 900,  800, 0,0,0,0, 0,      31'h00000005,   1, 0, 900, 1, 801, 0, 1, 1, 3);
    add(44,  2, 123,  456, 0,0,0,0, 1,      31'h00000005,   1, 0, 123, 1, 457, 0, 4, 1, 4);
    add(40,  0, 222,  333, 0,0,0,0, 0,      31'h40000003,   1, 0, 222, 1, 334, 0, 0, 1, 3);
    add(40,  6,  99,   50, 0,0,0,0, NO_ACK, 31'h0,          0, 1,  51, 0,  51, 0, 0, 1, RD_TMO + 2);
    add(39, 10,  77,   60, 0,0,0,1, NO_ACK, 31'h0,          0, 1,  61, 0,  61, 0, 0, 0, 2);
    add(38,  0,  77,   60, 0,0,0,0, NO_ACK, 31'h0,          0, 1,  61, 0,  61, 0, 0, 0, 2);
    add(45,  8,  77, 3999, 0,0,0,0, NO_ACK, 31'h0,          0, 1,   0, 0,   0, 0, 0, 0, 2);

    // Reset state.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_req", rd_req, 0);
    check("rst_pc_next", pc_next, 0);
    check("rst_outputs", {taken, illegal, pc_load, j_we, ovf_clr, j_data}, 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while waiting in RDREG discards the instruction.
    @(negedge clk);
    opcode = 6'd42;  field = 6'd0;  addr = 12'd5;  pc = 12'd6;  start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("mid_rd_req", rd_req, 1);
    check("mid_rd_idx", rd_idx, 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_rd_req", rd_req, 0);
    check("mid_rst_busy", busy, 0);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      if (done || pc_load || j_we || ovf_clr || rd_req) pulses++;
      @(negedge clk);
    end
    check("mid_rst_no_pulse", pulses, 0);

    // start while busy (EVAL) and during DONE is ignored; stray rd_ack is ignored.
    opcode = 6'd39;  field = 6'd0;  addr = 12'd500;  pc = 12'd100;
    cmp_l = 1'b0;  cmp_e = 1'b0;  cmp_g = 1'b0;  ovf = 1'b0;  start = 1'b1;
    @(negedge clk);
    opcode = 6'd47;  addr = 12'd9;  pc = 12'd8;  rd_ack = 1'b1;
    check("busy_eval", busy, 1);
    @(negedge clk);
    check("busy_done_pulse", done, 1);
    check("busy_pc_next", pc_next, 500);
    check("busy_j_data", j_data, 101);
    @(negedge clk);
    start = 1'b0;
    check("ignored_busy", busy, 0);
    check("ignored_rd_req", rd_req, 0);
    @(negedge clk);
    rd_ack = 1'b0;
    check("ignored_still_idle", busy, 0);
    check("ignored_no_done", done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
